// File: rtl/ro_meter_pkg.sv
// Shared definitions for the ring-oscillator readout (ro_meter) and related
// chain readouts: FSM state type, default sizing, and the timer width helper.
package ro_meter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    MEASURE,
    HOLD
  } meterState_t;

  localparam int unsigned DEF_WINDOW_CYCLES = 1024;
  localparam int unsigned DEF_SETTLE_CYCLES = 16;
  localparam int unsigned DEF_CNT_W         = 16;
  localparam int unsigned AVG_WINDOWS       = 4;

  // Width of a timer that must reach max(window, settle) - 1; never below 1 bit.
  function automatic int unsigned timerWidth(input int unsigned window,
                                             input int unsigned settle);
    int unsigned m;
    int unsigned w;
    m = (window > settle) ? window : settle;
    w = $clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/ro_sync_edge.sv
// Two-flop synchronizer for an asynchronous input followed by a registered
// rising-edge detector. rise is asserted for one clk cycle, three cycles after
// the input edge. Input toggles faster than clk/2 alias; this is not detected.
module ro_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic s1;
  logic s2;
  logic s3;

  // Synchronizer stages plus one history flop for the edge compare.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

endmodule

// File: rtl/ro_meter.sv
// Ring-oscillator readout: enables the loop, waits SETTLE_CYCLES, counts
// synchronized rising edges of ro_in over WINDOW_CYCLES clk cycles, and holds
// the (saturating) count behind a valid/ready handshake.
// Optional build macro RO_METER_AVG_EN: measure AVG_WINDOWS back-to-back
// windows and report the truncated average; overflow if any window saturated.
module ro_meter
  import ro_meter_pkg::*;
#(
  parameter int unsigned WINDOW_CYCLES = DEF_WINDOW_CYCLES,
  parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int unsigned CNT_W         = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             ro_en,
  input  logic             ro_in,
  output logic             busy,
  output logic [CNT_W-1:0] result,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             overflow
);

  localparam int unsigned      TW          = timerWidth(WINDOW_CYCLES, SETTLE_CYCLES);
  localparam logic [TW-1:0]    SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0]    WINDOW_LAST = TW'(WINDOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  meterState_t      state;
  meterState_t      stateNext;
  logic [TW-1:0]    timer;
  logic [CNT_W-1:0] edgeCnt;
  logic [CNT_W-1:0] cntNext;
  logic [CNT_W-1:0] captureVal;
  logic [CNT_W-1:0] resultR;
  logic             overflowR;
  logic             roEnR;
  logic             rise;
  logic             satHit;
  logic             settleEnd;
  logic             windowEnd;
  logic             measureDone;
  logic             clearCnt;

  ro_sync_edge uSyncEdge (
    .clk  (clk),
    .rst  (rst),
    .din  (ro_in),
    .rise (rise)
  );

  // Saturating edge-count increment and window/settle end strobes.
  always_comb begin
    satHit    = rise && (edgeCnt == CNT_MAX);
    cntNext   = (rise && !satHit) ? edgeCnt + CNT_W'(1) : edgeCnt;
    settleEnd = (state == SETTLE) && (timer == SETTLE_LAST);
    windowEnd = (state == MEASURE) && (timer == WINDOW_LAST);
  end

`ifdef RO_METER_AVG_EN
  logic [1:0]       winIdx;
  logic [CNT_W+1:0] winSum;
  logic [CNT_W+1:0] sumNext;

  // Sum including the current window's final count; average is sum / 4.
  always_comb begin
    sumNext     = winSum + {2'b00, cntNext};
    measureDone = windowEnd && (winIdx == 2'(AVG_WINDOWS - 1));
    clearCnt    = windowEnd;
    captureVal  = CNT_W'(sumNext >> 2);
  end

  // Window index and running sum, cleared on entry to MEASURE.
  always_ff @(posedge clk) begin
    if (rst) begin
      winIdx <= '0;
      winSum <= '0;
    end else if (settleEnd) begin
      winIdx <= '0;
      winSum <= '0;
    end else if (windowEnd) begin
      winIdx <= winIdx + 2'd1;
      winSum <= sumNext;
    end
  end
`else
  // Single window: the final count (including a rise on the last cycle) is the result.
  always_comb begin
    measureDone = windowEnd;
    clearCnt    = 1'b0;
    captureVal  = cntNext;
  end
`endif

  // Next-state logic.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (start)        stateNext = SETTLE;
      SETTLE:  if (settleEnd)    stateNext = MEASURE;
      MEASURE: if (measureDone)  stateNext = HOLD;
      HOLD:    if (result_ready) stateNext = IDLE;
      default:                   stateNext = IDLE;
    endcase
  end

  // State register, timer, edge counter, result capture and loop enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      timer     <= '0;
      edgeCnt   <= '0;
      overflowR <= 1'b0;
      resultR   <= '0;
      roEnR     <= 1'b0;
    end else begin
      state <= stateNext;
      // Registered so the gate into the chain is glitch-free.
      roEnR <= (stateNext == SETTLE) || (stateNext == MEASURE);
      case (state)
        IDLE: begin
          if (start) timer <= '0;
        end
        SETTLE: begin
          if (settleEnd) begin
            timer     <= '0;
            edgeCnt   <= '0;
            overflowR <= 1'b0;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        MEASURE: begin
          edgeCnt <= clearCnt ? '0 : cntNext;
          if (satHit) overflowR <= 1'b1;
          timer <= windowEnd ? '0 : timer + TW'(1);
          if (measureDone) resultR <= captureVal;
        end
        default: ;
      endcase
    end
  end

  assign ro_en        = roEnR;
  assign busy         = (state == SETTLE) || (state == MEASURE);
  assign result_valid = (state == HOLD);
  assign result       = resultR;
  assign overflow     = overflowR;

endmodule

// File: tb/tb_ro_meter.sv
// Self-checking bench for ro_meter. Two instances: a default-sized one (A) and
// a narrow-counter one (B) for saturation. The reference model counts rising
// transitions in the per-clk samples of ro_in, shifted by the 3-cycle edge
// latency, over each measurement window.
module tb_ro_meter;

  localparam int WA  = 1024;
  localparam int SA  = 16;
  localparam int CWA = 16;
  localparam int WB  = 128;
  localparam int SB  = 5;
  localparam int CWB = 4;
`ifdef RO_METER_AVG_EN
  localparam int NW = 4;
`else
  localparam int NW = 1;
`endif
  localparam int HMAX = 131072;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic roIn = 1'b0;
  logic startA = 1'b0, readyA = 1'b0, startB = 1'b0, readyB = 1'b0;
  logic roEnA, busyA, validA, ovfA;
  logic roEnB, busyB, validB, ovfB;
  logic [CWA-1:0] resultA;
  logic [CWB-1:0] resultB;

  int nCmp = 0;
  int nFail = 0;
  int cyc = 0;
  bit hist [HMAX];

  int mode = 0;    // 0 constant level, 1 square wave, 2 random
  bit level = 1'b0;
  int period = 8;
  int ph = 0;

  always #5 clk = ~clk;

  ro_meter #(.WINDOW_CYCLES(WA), .SETTLE_CYCLES(SA), .CNT_W(CWA)) dutA (
    .clk(clk), .rst(rst), .start(startA), .ro_en(roEnA), .ro_in(roIn),
    .busy(busyA), .result(resultA), .result_valid(validA),
    .result_ready(readyA), .overflow(ovfA)
  );

  ro_meter #(.WINDOW_CYCLES(WB), .SETTLE_CYCLES(SB), .CNT_W(CWB)) dutB (
    .clk(clk), .rst(rst), .start(startB), .ro_en(roEnB), .ro_in(roIn),
    .busy(busyB), .result(resultB), .result_valid(validB),
    .result_ready(readyB), .overflow(ovfB)
  );

  // Record the value of ro_in at every clk edge; cyc = edges seen so far.
  always @(posedge clk) begin
    if (cyc < HMAX) hist[cyc] <= roIn;
    cyc <= cyc + 1;
  end

  // Oscillator stand-in: changes shortly after each edge.
  always @(posedge clk) begin
    #1;
    case (mode)
      1: begin
        roIn = ((ph % period) < (period / 2));
        ph++;
      end
      2: roIn = 1'($urandom_range(0, 1));
      default: roIn = level;
    endcase
  end

  // Expected result/overflow for a run whose start was accepted at edge e0.
  function automatic void model(input int e0, input int s, input int w, input int cw,
                                output int res, output bit ovf);
    int m0, mx, sum, c;
    m0 = e0 + s;
    mx = (1 << cw) - 1;
    sum = 0;
    ovf = 1'b0;
    for (int wi = 0; wi < NW; wi++) begin
      c = 0;
      for (int n = m0 + wi * w; n < m0 + (wi + 1) * w; n++)
        if (hist[n - 1] && !hist[n - 2]) c++;
      if (c > mx) begin
        ovf = 1'b1;
        c = mx;
      end
      sum += c;
    end
    res = sum / NW;
  endfunction

  // Launch one measurement on instance sel and wait (bounded) for result_valid.
  task automatic runMeas(input int sel, input bit midStart, output int lat, output int e0,
                         output int busyBad);
    int s, w;
    logic v, b;
    s = (sel == 0) ? SA : SB;
    w = (sel == 0) ? WA : WB;
    busyBad = 0;
    @(negedge clk);
    e0 = cyc;
    if (sel == 0) startA = 1'b1; else startB = 1'b1;
    lat = 0;
    v = 1'b0;
    while (!v && lat < 5000 + NW * w) begin
      @(negedge clk);
      lat = cyc - e0;
      if (sel == 0) begin
        startA = midStart && (lat == s + 50);
        v = validA; b = busyA;
      end else begin
        startB = midStart && (lat == s + 20);
        v = validB; b = busyB;
      end
      if (!v && b !== 1'b1) busyBad++;
    end
    startA = 1'b0;
    startB = 1'b0;
  endtask

  task automatic releaseResult(input int sel);
    @(negedge clk);
    if (sel == 0) readyA = 1'b1; else readyB = 1'b1;
    @(negedge clk);
    readyA = 1'b0;
    readyB = 1'b0;
  endtask

  // Run one measurement and compare latency, result and overflow with the model.
  task automatic checkRun(input string name, input int sel, input bit midStart,
                          output int expRes, output bit expOvf);
    int lat, e0, bb, s, w, cw, expLat;
    logic [31:0] got;
    logic gotOvf;
    s  = (sel == 0) ? SA : SB;
    w  = (sel == 0) ? WA : WB;
    cw = (sel == 0) ? CWA : CWB;
    expLat = 1 + s + NW * w;
    runMeas(sel, midStart, lat, e0, bb);
    model(e0, s, w, cw, expRes, expOvf);
    got    = (sel == 0) ? 32'(resultA) : 32'(resultB);
    gotOvf = (sel == 0) ? ovfA : ovfB;
    nCmp++;
    if (lat !== expLat) begin
      nFail++;
      $display("FAIL %s latency: got %0d required %0d", name, lat, expLat);
    end
    nCmp++;
    if (got !== 32'(expRes)) begin
      nFail++;
      $display("FAIL %s result: got %0d required %0d", name, got, expRes);
    end
    nCmp++;
    if (gotOvf !== expOvf) begin
      nFail++;
      $display("FAIL %s overflow: got %b required %b", name, gotOvf, expOvf);
    end
    nCmp++;
    if (bb !== 0) begin
      nFail++;
      $display("FAIL %s busy: %0d cycles low before result required 0", name, bb);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    nCmp++;
    if ({roEnA, busyA, validA, ovfA, resultA} !== '0) begin
      nFail++;
      $display("FAIL reset_A: got %b required all 0", {roEnA, busyA, validA, ovfA, resultA});
    end
    nCmp++;
    if ({roEnB, busyB, validB, ovfB, resultB} !== '0) begin
      nFail++;
      $display("FAIL reset_B: got %b required all 0", {roEnB, busyB, validB, ovfB, resultB});
    end
    rst = 1'b0;
    begin
      int bad = 0;
      mode = 1; period = 6;
      repeat (100) begin
        @(negedge clk);
        if ({roEnA, busyA, validA, roEnB, busyB, validB} !== '0) bad++;
      end
      nCmp++;
      if (bad != 0) begin
        nFail++;
        $display("FAIL idle_no_start: %0d active cycles required 0", bad);
      end
    end
  endtask

  task automatic test_square();
    int r; bit o;
    mode = 1; period = 8; ph = 0;
    checkRun("square8", 0, 1'b0, r, o);
    nCmp++;
    if (resultA < 127 || resultA > 129) begin
      nFail++;
      $display("FAIL square8_range: got %0d required 128 +/-1", resultA);
    end
    nCmp++;
    if ({roEnA, busyA, validA} !== 3'b001) begin
      nFail++;
      $display("FAIL square8_hold_flags: got ro_en/busy/valid=%b required 001", {roEnA, busyA, validA});
    end
    releaseResult(0);
    nCmp++;
    if (validA !== 1'b0) begin
      nFail++;
      $display("FAIL square8_release: valid got %b required 0", validA);
    end
  endtask

  task automatic test_saturate();
    int r; bit o;
    mode = 1; period = 4; ph = 0;
    checkRun("sat4", 1, 1'b0, r, o);
    nCmp++;
    if (resultB !== 4'd15 || ovfB !== 1'b1) begin
      nFail++;
      $display("FAIL sat4_fixed: got result=%0d ovf=%b required 15/1", resultB, ovfB);
    end
    releaseResult(1);
    period = 64; ph = 0;
    checkRun("slow64", 1, 1'b0, r, o);
    nCmp++;
    if (ovfB !== 1'b0 || resultB < 4'd1 || resultB > 4'd3) begin
      nFail++;
      $display("FAIL slow64_fixed: got result=%0d ovf=%b required 2(+/-1)/0", resultB, ovfB);
    end
    releaseResult(1);
  endtask

  task automatic test_hold_and_ignore();
    int r, bad; bit o;
    mode = 2;
    checkRun("hold_midstart", 0, 1'b1, r, o);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      startA = (i % 10 == 3);
      if (validA !== 1'b1 || 32'(resultA) !== 32'(r) || ovfA !== o ||
          roEnA !== 1'b0 || busyA !== 1'b0) bad++;
    end
    startA = 1'b0;
    nCmp++;
    if (bad != 0) begin
      nFail++;
      $display("FAIL hold_stable: %0d unstable cycles required 0", bad);
    end
    @(negedge clk);
    startA = 1'b1; readyA = 1'b1;
    @(negedge clk);
    startA = 1'b0; readyA = 1'b0;
    nCmp++;
    if ({validA, busyA, roEnA} !== 3'b000) begin
      nFail++;
      $display("FAIL start_with_ready: got valid/busy/ro_en=%b required 000", {validA, busyA, roEnA});
    end
    repeat (5) @(negedge clk);
    nCmp++;
    if (busyA !== 1'b0 || 32'(resultA) !== 32'(r)) begin
      nFail++;
      $display("FAIL idle_after_hold: got busy=%b result=%0d required 0/%0d", busyA, resultA, r);
    end
  endtask

  task automatic test_reset_mid();
    int r; bit o;
    mode = 1; period = 16; ph = 0;
    @(negedge clk);
    startA = 1'b1;
    @(negedge clk);
    startA = 1'b0;
    repeat (SA + 200) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    nCmp++;
    if ({roEnA, busyA, validA} !== 3'b000) begin
      nFail++;
      $display("FAIL reset_mid: got ro_en/busy/valid=%b required 000", {roEnA, busyA, validA});
    end
    mode = 2;
    checkRun("after_reset", 0, 1'b0, r, o);
    releaseResult(0);
  endtask

  task automatic test_stuck();
    int r; bit o;
    mode = 0; level = 1'b1;
    checkRun("stuck_high", 0, 1'b0, r, o);
    nCmp++;
    if (resultA !== '0 || ovfA !== 1'b0) begin
      nFail++;
      $display("FAIL stuck_high_fixed: got result=%0d ovf=%b required 0/0", resultA, ovfA);
    end
    releaseResult(0);
    level = 1'b0;
    checkRun("stuck_low", 1, 1'b0, r, o);
    nCmp++;
    if (resultB !== '0 || ovfB !== 1'b0) begin
      nFail++;
      $display("FAIL stuck_low_fixed: got result=%0d ovf=%b required 0/0", resultB, ovfB);
    end
    releaseResult(1);
  endtask

  task automatic test_random();
    int r; bit o;
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) begin
        mode = 2;
      end else begin
        mode = 1;
        period = int'($urandom_range(20, 60));
        ph = int'($urandom_range(0, 40));
      end
      checkRun("random_B", 1, 1'b0, r, o);
      releaseResult(1);
    end
    mode = 1; period = int'($urandom_range(3, 12)); ph = 0;
    checkRun("random_A", 0, 1'b0, r, o);
    releaseResult(0);
  endtask

  initial begin
    test_reset();
    test_square();
    test_saturate();
    test_hold_and_ignore();
    test_reset_mid();
    test_stuck();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
